mont_mul_ws: RTL

MONT_MUL_WS -- requirements
Module: mont_mul_ws

---
 rtl/mont_mul_ws.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mont_mul_ws.sv
// mont_mul_ws: word-serial Montgomery multiplier (CIOS), a = x*y*2^(-N*K) mod p.
// Operands x, y, p stream in one K-bit word per beat, LSW first; -p^-1 mod 2^K is
// taken on the first beat. The result streams out LSW first with valid/ready.
// Build option MONT_MUL_FINAL_SUB_EN: when defined, a final conditional subtraction
// makes the result < p. When undefined, the raw result (< 2p) is output and bit N*K
// appears on out_carry for the whole burst.
module mont_mul_ws #(
  parameter int unsigned K      = 64,
  parameter int unsigned N      = 32,
  parameter int unsigned ADDR_W = $clog2(N + 2)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] in_x,
  input  logic [K-1:0] in_y,
  input  logic [K-1:0] in_p,
  input  logic [K-1:0] in_p1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_data,
  output logic         out_last,
  output logic         out_carry,
  output logic         busy
);

  typedef enum logic [2:0] {StIdle, StMul, StRed, StSub, StOut} state_e;

  state_e            state;
  logic [ADDR_W-1:0] i_cnt;
  logic [ADDR_W-1:0] j_cnt;
  logic [K-1:0]      x_mem [N];
  logic [K-1:0]      y_mem [N];
  logic [K-1:0]      p_mem [N];
  logic [K-1:0]      a_mem [N+2];
  logic [K-1:0]      m_reg;
  logic [K-1:0]      p1_reg;
  logic [K-1:0]      carry;

  // Word reads selected by the running counters
  logic [K-1:0]      x_j;
  logic [K-1:0]      y_i;
  logic [K-1:0]      p_j;
  logic [K-1:0]      a_j;
  logic [K-1:0]      a_nxt;
  logic [K-1:0]      out_nxt;
  logic [ADDR_W-1:0] j_inc;

  // Shared multiply-accumulate datapath
  logic [K-1:0]      m_new;
  logic [K-1:0]      m_use;
  logic [K-1:0]      mul_a;
  logic [K-1:0]      mul_b;
  logic [2*K-1:0]    prod;
  logic [2*K-1:0]    acc;
  logic [K:0]        top_sum;
  logic [K-1:0]      a_top_new;

`ifdef MONT_MUL_FINAL_SUB_EN
  logic [K-1:0]      d_mem [N];
  logic [K-1:0]      d_nxt;
  logic              borrow;
  logic              sel_d;
  logic [K:0]        diff;
  logic              take_d;
`endif

  assign j_inc = j_cnt + ADDR_W'(1);

  // Word-select muxes for operands, accumulator and the next output word
  always_comb begin
    x_j   = '0;
    y_i   = '0;
    p_j   = '0;
    a_j   = '0;
    a_nxt = '0;
`ifdef MONT_MUL_FINAL_SUB_EN
    d_nxt = '0;
`endif
    for (int k = 0; k < N; k++) begin
      if (j_cnt == ADDR_W'(k)) begin
        x_j = x_mem[k];
        p_j = p_mem[k];
      end
      if (i_cnt == ADDR_W'(k)) y_i = y_mem[k];
      if (j_inc == ADDR_W'(k)) begin
        a_nxt = a_mem[k];
`ifdef MONT_MUL_FINAL_SUB_EN
        d_nxt = d_mem[k];
`endif
      end
    end
    for (int k = 0; k < N + 2; k++) begin
      if (j_cnt == ADDR_W'(k)) a_j = a_mem[k];
    end
  end

  // m is only needed mod 2^K, so a K-bit product is exact here
  assign m_new     = a_mem[0] * p1_reg;
  assign m_use     = (j_cnt == '0) ? m_new : m_reg;
  assign mul_a     = (state == StMul) ? x_j : m_use;
  assign mul_b     = (state == StMul) ? y_i : p_j;
  assign prod      = {{K{1'b0}}, mul_a} * {{K{1'b0}}, mul_b};
  // Cannot overflow 2K bits: (2^K-1) + (2^K-1)^2 + (2^K-1) = 2^2K - 1
  assign acc       = {{K{1'b0}}, a_j} + prod + {{K{1'b0}}, carry};
  assign top_sum   = {1'b0, a_mem[N]} + {1'b0, carry};
  assign a_top_new = a_mem[N+1] + {{(K-1){1'b0}}, top_sum[K]};

`ifdef MONT_MUL_FINAL_SUB_EN
  assign diff    = {1'b0, a_j} - {1'b0, p_j} - {{K{1'b0}}, borrow};
  // On the last SUB word: a >= p exactly when a[N] is set or nothing was borrowed
  assign take_d  = (a_mem[N] != '0) || !diff[K];
  assign out_nxt = sel_d ? d_nxt : a_nxt;
`else
  assign out_nxt = a_nxt;
`endif

  // Control FSM, word arrays and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      i_cnt     <= '0;
      j_cnt     <= '0;
      m_reg     <= '0;
      p1_reg    <= '0;
      carry     <= '0;
      for (int k = 0; k < N; k++) begin
        x_mem[k] <= '0;
        y_mem[k] <= '0;
        p_mem[k] <= '0;
      end
      for (int k = 0; k < N + 2; k++) a_mem[k] <= '0;
`ifdef MONT_MUL_FINAL_SUB_EN
      for (int k = 0; k < N; k++) d_mem[k] <= '0;
      borrow    <= 1'b0;
      sel_d     <= 1'b0;
`endif
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_carry <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            for (int k = 0; k < N; k++) begin
              if (j_cnt == ADDR_W'(k)) begin
                x_mem[k] <= in_x;
                y_mem[k] <= in_y;
                p_mem[k] <= in_p;
              end
            end
            if (j_cnt == '0) p1_reg <= in_p1;
            if (j_cnt == ADDR_W'(N - 1)) begin
              for (int k = 0; k < N + 2; k++) a_mem[k] <= '0;
              state    <= StMul;
              i_cnt    <= '0;
              j_cnt    <= '0;
              carry    <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              j_cnt <= j_inc;
            end
          end
        end

        StMul: begin
          if (j_cnt == ADDR_W'(N)) begin
            a_mem[N]   <= top_sum[K-1:0];
            a_mem[N+1] <= {{(K-1){1'b0}}, top_sum[K]};
            carry      <= '0;
            j_cnt      <= '0;
            state      <= StRed;
          end else begin
            for (int k = 0; k < N; k++) begin
              if (j_cnt == ADDR_W'(k)) a_mem[k] <= acc[K-1:0];
            end
            carry <= acc[2*K-1:K];
            j_cnt <= j_inc;
          end
        end

        StRed: begin
          if (j_cnt == '0) begin
            // Low word of a + m*p is zero by construction; keep only the carry
            m_reg <= m_new;
            carry <= acc[2*K-1:K];
            j_cnt <= j_inc;
          end else if (j_cnt == ADDR_W'(N)) begin
            a_mem[N-1] <= top_sum[K-1:0];
            a_mem[N]   <= a_top_new;
            carry      <= '0;
            j_cnt      <= '0;
            if (i_cnt == ADDR_W'(N - 1)) begin
              i_cnt <= '0;
`ifdef MONT_MUL_FINAL_SUB_EN
              borrow <= 1'b0;
              state  <= StSub;
`else
              // a[0] was finalised at j=1 of this pass, so it is safe to present now
              state     <= StOut;
              out_valid <= 1'b1;
              out_data  <= a_mem[0];
              out_last  <= 1'b0;
              out_carry <= (a_top_new != '0);
`endif
            end else begin
              i_cnt <= i_cnt + ADDR_W'(1);
              state <= StMul;
            end
          end else begin
            for (int k = 1; k < N; k++) begin
              if (j_cnt == ADDR_W'(k)) a_mem[k-1] <= acc[K-1:0];
            end
            carry <= acc[2*K-1:K];
            j_cnt <= j_inc;
          end
        end

`ifdef MONT_MUL_FINAL_SUB_EN
        StSub: begin
          for (int k = 0; k < N; k++) begin
            if (j_cnt == ADDR_W'(k)) d_mem[k] <= diff[K-1:0];
          end
          borrow <= diff[K];
          if (j_cnt == ADDR_W'(N - 1)) begin
            sel_d     <= take_d;
            state     <= StOut;
            j_cnt     <= '0;
            out_valid <= 1'b1;
            out_data  <= take_d ? d_mem[0] : a_mem[0];
            out_last  <= 1'b0;
            out_carry <= 1'b0;
          end else begin
            j_cnt <= j_inc;
          end
        end
`endif

        StOut: begin
          if (out_ready) begin
            if (j_cnt == ADDR_W'(N - 1)) begin
              state     <= StIdle;
              j_cnt     <= '0;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_last  <= 1'b0;
              out_carry <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              j_cnt    <= j_inc;
              out_data <= out_nxt;
              out_last <= (j_inc == ADDR_W'(N - 1));
            end
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule
